// File: rtl/uart_pkg.sv
// Definitions shared by the UART receiver and transmitter: FSM state encoding,
// parity-mode constants and the 2-of-3 majority vote used for bit sampling.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    PARITY     = 3'd3,
    STOP       = 3'd4,
    BREAK_WAIT = 3'd5
  } uart_state_e;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO; a push into a full FIFO succeeds only
// when a pop frees a slot in the same cycle.
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CNTW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CNTW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  // Gating on empty keeps the head at zero after reset without resetting the array.
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: synchronised line, 3-sample majority per bit,
// optional parity, 1/2 stop bits, break handling and a FWFT receive FIFO.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_MULT   = 139,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY_MODE = PARITY_NONE,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                          i_uart_clk,
  input  logic                          i_rst_n,
  input  logic                          i_rx_data,
  output logic [DATA_BITS-1:0]          o_byte_out,
  output logic                          o_data_valid,
  input  logic                          i_rx_ready,
  output logic                          o_rx_active,
  output logic                          o_frame_err,
  output logic                          o_parity_err,
  output logic                          o_overrun,
  input  logic                          i_err_clr,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic                          o_dbg_state
);

  localparam int unsigned CW       = $clog2(BAUD_MULT);
  localparam int unsigned MID      = BAUD_MULT >> 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_MULT - 1);
  localparam logic [CW-1:0] CNT_S0   = CW'(MID - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(MID);
  localparam logic [CW-1:0] CNT_S2   = CW'(MID + 1);
  localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic          PAR_ODD   = (PARITY_MODE == PARITY_ODD);

  logic                 rx_meta_q, rx_sync_q, rx_prev_q;
  uart_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [1:0]           smp_q, smp_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bad_q, par_bad_d;
  logic                 push_q, push_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_q, overrun_d;

  logic                 maj, at_s2, at_last;
  logic                 frame_set, parity_set, overrun_set;
  logic                 fifo_full, fifo_empty, fifo_pop;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    smp_d      = smp_q;
    shift_d    = shift_q;
    par_bad_d  = par_bad_q;
    push_d     = 1'b0;
    frame_set  = 1'b0;
    parity_set = 1'b0;
    maj        = maj3(smp_q[0], smp_q[1], rx_sync_q);
    at_s2      = (cnt_q == CNT_S2);
    at_last    = (cnt_q == CNT_LAST);

    if (state_q inside {START, DATA, PARITY, STOP}) begin
      cnt_d = at_last ? '0 : cnt_q + CW'(1);
      if (cnt_q == CNT_S0) smp_d[0] = rx_sync_q;
      if (cnt_q == CNT_S1) smp_d[1] = rx_sync_q;
    end

    case (state_q)
      IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          state_d   = START;
          cnt_d     = '0;
          bit_cnt_d = '0;
          par_bad_d = 1'b0;
        end
      end
      START: begin
        if (at_s2 && maj) state_d = IDLE;
        else if (at_last) state_d = DATA;
      end
      DATA: begin
        if (at_s2) shift_d = {maj, shift_q[DATA_BITS-1:1]};
        if (at_last) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (at_s2 && (((^shift_q) ^ maj) != PAR_ODD)) begin
          parity_set = 1'b1;
          par_bad_d  = 1'b1;
        end
        if (at_last) state_d = STOP;
      end
      STOP: begin
        // Good frames leave a half bit early so a back-to-back start edge is seen.
        if (at_s2 && !maj) begin
          frame_set = 1'b1;
          state_d   = BREAK_WAIT;
          cnt_d     = '0;
        end else if (at_s2 && (bit_cnt_q == STOP_LAST)) begin
          push_d  = !par_bad_q;
          state_d = IDLE;
        end else if (at_last) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      BREAK_WAIT: begin
        if (!rx_sync_q) begin
          cnt_d = '0;
        end else if (at_last) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    overrun_set  = push_q && fifo_full && !fifo_pop;
    frame_err_d  = i_err_clr ? 1'b0 : (frame_err_q  | frame_set);
    parity_err_d = i_err_clr ? 1'b0 : (parity_err_q | parity_set);
    overrun_d    = i_err_clr ? 1'b0 : (overrun_q    | overrun_set);
  end

  always_ff @(posedge i_uart_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      smp_q        <= '1;
      shift_q      <= '0;
      par_bad_q    <= 1'b0;
      push_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rx_meta_q    <= i_rx_data;
      rx_sync_q    <= rx_meta_q;
      rx_prev_q    <= rx_sync_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      smp_q        <= smp_d;
      shift_q      <= shift_d;
      par_bad_q    <= par_bad_d;
      push_q       <= push_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign fifo_pop = !fifo_empty && i_rx_ready;

  uart_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_uart_clk),
    .rst_n (i_rst_n),
    .push  (push_q),
    .wdata (shift_q),
    .pop   (fifo_pop),
    .rdata (o_byte_out),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (o_fifo_count)
  );

  assign o_data_valid = !fifo_empty;
  assign o_rx_active  = state_q inside {START, DATA, PARITY, STOP};
  assign o_dbg_state  = (state_q == IDLE);
  assign o_frame_err  = frame_err_q;
  assign o_parity_err = parity_err_q;
  assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: an 8N1 receiver and an 8E1 receiver, both at 16
// clocks per bit; received bytes are scored against expectation queues.
module tb_uart_rx_cfg;

  localparam int unsigned BM = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic rx_a, rx_b, rdy_a, rdy_b, clr_a, clr_b;
  logic [7:0] byte_a, byte_b;
  logic val_a, val_b, act_a, act_b, ferr_a, ferr_b, perr_a, perr_b;
  logic ovr_a, ovr_b, dbg_a, dbg_b;
  logic [2:0] cnt_a, cnt_b;

  int unsigned n_vec    = 0;
  int unsigned n_miscmp = 0;
  logic [7:0]  sb_a[$];
  logic [7:0]  sb_b[$];
  logic [7:0]  exp_a, exp_b;
  logic [7:0]  pat;

  always #5 clk = ~clk;

  uart_rx_cfg #(
    .BAUD_MULT   (BM),
    .DATA_BITS   (8),
    .PARITY_MODE (0),
    .STOP_BITS   (1),
    .FIFO_DEPTH  (4)
  ) u_dut_a (
    .i_uart_clk   (clk),
    .i_rst_n      (rst_n),
    .i_rx_data    (rx_a),
    .o_byte_out   (byte_a),
    .o_data_valid (val_a),
    .i_rx_ready   (rdy_a),
    .o_rx_active  (act_a),
    .o_frame_err  (ferr_a),
    .o_parity_err (perr_a),
    .o_overrun    (ovr_a),
    .i_err_clr    (clr_a),
    .o_fifo_count (cnt_a),
    .o_dbg_state  (dbg_a)
  );

  uart_rx_cfg #(
    .BAUD_MULT   (BM),
    .DATA_BITS   (8),
    .PARITY_MODE (1),
    .STOP_BITS   (1),
    .FIFO_DEPTH  (4)
  ) u_dut_b (
    .i_uart_clk   (clk),
    .i_rst_n      (rst_n),
    .i_rx_data    (rx_b),
    .o_byte_out   (byte_b),
    .o_data_valid (val_b),
    .i_rx_ready   (rdy_b),
    .o_rx_active  (act_b),
    .o_frame_err  (ferr_b),
    .o_parity_err (perr_b),
    .o_overrun    (ovr_b),
    .i_err_clr    (clr_b),
    .o_fifo_count (cnt_b),
    .o_dbg_state  (dbg_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input bit on_b, input logic b, input int unsigned cycles);
    if (on_b) rx_b = b;
    else      rx_a = b;
    tick(cycles);
  endtask

  task automatic send_frame(input bit on_b, input logic [7:0] d, input bit with_par,
                            input logic par, input logic stop);
    drive(on_b, 1'b0, BM);
    for (int unsigned i = 0; i < 8; i++) drive(on_b, d[i], BM);
    if (with_par) drive(on_b, par, BM);
    drive(on_b, stop, BM);
  endtask

  // Scoreboards: every byte the consumer accepts must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && val_a && rdy_a) begin
      if (sb_a.size() == 0) begin
        check_eq("sb_a_extra_pop", 32'(sb_a.size()), 32'd1);
      end else begin
        exp_a = sb_a.pop_front();
        check_eq("byte_a", 32'(byte_a), 32'(exp_a));
      end
    end
    if (rst_n && val_b && rdy_b) begin
      if (sb_b.size() == 0) begin
        check_eq("sb_b_extra_pop", 32'(sb_b.size()), 32'd1);
      end else begin
        exp_b = sb_b.pop_front();
        check_eq("byte_b", 32'(byte_b), 32'(exp_b));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    rx_a  = 1'b1;
    rx_b  = 1'b1;
    rdy_a = 1'b0;
    rdy_b = 1'b1;
    clr_a = 1'b0;
    clr_b = 1'b0;
    tick(3);
    check_eq("rst_byte",  32'(byte_a), 32'd0);
    check_eq("rst_valid", 32'(val_a),  32'd0);
    check_eq("rst_active", 32'(act_a), 32'd0);
    check_eq("rst_flags", 32'({ferr_a, perr_a, ovr_a}), 32'd0);
    check_eq("rst_count", 32'(cnt_a),  32'd0);
    check_eq("rst_dbg",   32'(dbg_a),  32'd1);
    rst_n = 1'b1;
    tick(3);

    // 8N1 frame 0xA5, then pop with ready held high
    sb_a.push_back(8'hA5);
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
    tick(4);
    check_eq("a5_valid", 32'(val_a),  32'd1);
    check_eq("a5_head",  32'(byte_a), 32'hA5);
    check_eq("a5_count", 32'(cnt_a),  32'd1);
    check_eq("a5_flags", 32'({ferr_a, perr_a, ovr_a}), 32'd0);
    rdy_a = 1'b1;
    tick(1);
    check_eq("a5_popped_valid", 32'(val_a), 32'd0);
    check_eq("a5_popped_count", 32'(cnt_a), 32'd0);

    // 6-cycle glitch on idle line
    rx_a = 1'b0;
    tick(6);
    check_eq("glitch_active", 32'(act_a), 32'd1);
    rx_a = 1'b1;
    tick(20);
    check_eq("glitch_idle",  32'(dbg_a), 32'd1);
    check_eq("glitch_active_low", 32'(act_a), 32'd0);
    check_eq("glitch_count", 32'(cnt_a), 32'd0);
    check_eq("glitch_flags", 32'({ferr_a, perr_a, ovr_a}), 32'd0);

    // stop bit low -> frame error, break wait until 16 high cycles
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, BM);
    check_eq("brk_dbg",    32'(dbg_a),  32'd0);
    check_eq("brk_active", 32'(act_a),  32'd0);
    check_eq("brk_ferr",   32'(ferr_a), 32'd1);
    check_eq("brk_count",  32'(cnt_a),  32'd0);
    rx_a = 1'b1;
    tick(17);
    check_eq("brk_hold", 32'(dbg_a), 32'd0);
    tick(1);
    check_eq("brk_exit", 32'(dbg_a), 32'd1);
    check_eq("ferr_sticky", 32'(ferr_a), 32'd1);
    clr_a = 1'b1;
    tick(1);
    clr_a = 1'b0;
    check_eq("ferr_clear", 32'(ferr_a), 32'd0);

    // five frames into a depth-4 FIFO with no consumer
    rdy_a = 1'b0;
    for (int unsigned v = 1; v <= 5; v++) begin
      if (v <= 4) sb_a.push_back(8'(v));
      send_frame(1'b0, 8'(v), 1'b0, 1'b0, 1'b1);
    end
    tick(4);
    check_eq("ovr_count", 32'(cnt_a),  32'd4);
    check_eq("ovr_flag",  32'(ovr_a),  32'd1);
    check_eq("ovr_head",  32'(byte_a), 32'h01);
    rdy_a = 1'b1;
    tick(8);
    rdy_a = 1'b0;
    check_eq("ovr_drained", 32'(cnt_a), 32'd0);
    check_eq("ovr_sb_empty", 32'(sb_a.size()), 32'd0);

    // reset in the middle of data bit 3, with a byte pending and overrun set
    send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
    pat = 8'h5A;
    drive(1'b0, 1'b0, BM);
    for (int unsigned i = 0; i < 3; i++) drive(1'b0, pat[i], BM);
    drive(1'b0, pat[3], BM / 2);
    check_eq("pre_rst_active", 32'(act_a), 32'd1);
    check_eq("pre_rst_valid",  32'(val_a), 32'd1);
    check_eq("pre_rst_ovr",    32'(ovr_a), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid",  32'(val_a),  32'd0);
    check_eq("mid_rst_byte",   32'(byte_a), 32'd0);
    check_eq("mid_rst_count",  32'(cnt_a),  32'd0);
    check_eq("mid_rst_active", 32'(act_a),  32'd0);
    check_eq("mid_rst_dbg",    32'(dbg_a),  32'd1);
    check_eq("mid_rst_flags",  32'({ferr_a, perr_a, ovr_a}), 32'd0);
    sb_a.delete();
    rx_a = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(3);
    rdy_a = 1'b1;
    sb_a.push_back(8'h5A);
    send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
    tick(4);
    check_eq("post_rst_sb_empty", 32'(sb_a.size()), 32'd0);
    check_eq("post_rst_count", 32'(cnt_a), 32'd0);
    check_eq("post_rst_flags", 32'({ferr_a, perr_a, ovr_a}), 32'd0);

    // even parity: 0x03 with parity 1 is bad, 0x07 with parity 1 is good
    send_frame(1'b1, 8'h03, 1'b1, 1'b1, 1'b1);
    tick(4);
    check_eq("par_err",   32'(perr_b), 32'd1);
    check_eq("par_count", 32'(cnt_b),  32'd0);
    check_eq("par_valid", 32'(val_b),  32'd0);
    check_eq("par_ferr",  32'(ferr_b), 32'd0);
    clr_b = 1'b1;
    tick(1);
    clr_b = 1'b0;
    check_eq("par_clear", 32'(perr_b), 32'd0);
    sb_b.push_back(8'h07);
    send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
    tick(4);
    check_eq("par_good_sb_empty", 32'(sb_b.size()), 32'd0);
    check_eq("par_good_no_err",   32'(perr_b), 32'd0);
    check_eq("par_good_count",    32'(cnt_b),  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
